// File: rtl/p405s_icu_dp_regqueue.sv
// First-word-fall-through circular register queue with a registered head
// word, global clock enable, synchronous flush and sticky over/underflow flags.
module p405s_icu_dp_regqueue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input  logic             CB,
   input  logic             resetN,
   input  logic             E1,
   input  logic [0:WIDTH-1] D,
   input  logic             wrEn,
   input  logic             rdEn,
   input  logic             flush,
   output logic [0:WIDTH-1] L2,
   output logic             valid,
   output logic             full,
   output logic [0:CW-1]    count,
   output logic             ovfl,
   output logic             unfl
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_nxt;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic             live;
   logic             pop;
   logic             push;
   logic             ovfl_hit;
   logic             unfl_hit;

   assign live     = E1 & ~flush;
   assign pop      = live & rdEn & valid;
   assign push     = live & wrEn & (~full | pop);
   assign ovfl_hit = live & wrEn & full & ~pop;
   assign unfl_hit = live & rdEn & ~valid;
   assign rd_nxt   = rd_ptr + AW'(1);
   assign count    = cnt;

   always_comb begin
      cnt_nxt = cnt;
      if (push && !pop)
         cnt_nxt = cnt + CW'(1);
      else if (pop && !push)
         cnt_nxt = cnt - CW'(1);
   end

   // Storage is deliberately unreset; L2 only ever loads written words.
   always_ff @(posedge CB) begin
      if (push)
         mem[wr_ptr] <= D;
   end

   always_ff @(posedge CB or negedge resetN) begin
      if (!resetN) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         valid  <= 1'b0;
         full   <= 1'b0;
         ovfl   <= 1'b0;
         unfl   <= 1'b0;
         L2     <= '0;
      end else if (E1) begin
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            valid  <= 1'b0;
            full   <= 1'b0;
            ovfl   <= 1'b0;
            unfl   <= 1'b0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + AW'(1);
            if (pop)
               rd_ptr <= rd_nxt;
            cnt   <= cnt_nxt;
            valid <= (cnt_nxt != '0);
            full  <= (cnt_nxt == DEPTH_C);
            ovfl  <= ovfl | ovfl_hit;
            unfl  <= unfl | unfl_hit;
            // Head comes from storage if another entry remains, else bypasses D.
            if (pop && (cnt > CW'(1)))
               L2 <= mem[rd_nxt];
            else if (push && ((cnt == '0) || pop))
               L2 <= D;
         end
      end
   end

endmodule
